inst_sram_axi_rd: RTL and testbench

INST_SRAM_AXI_RD -- requirements
Module: inst_sram_axi_rd

---
 rtl/inst_sram_axi_rd.sv | 144 ++++++++++++++
 tb/tb_inst_sram_axi_rd.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_axi_rd.sv
// rtl/inst_sram_axi_rd.sv - instruction SRAM-like fetch port to AXI read bridge
//
// Purpose: converts pre-IF SRAM-style fetch requests (req/addr_ok/data_ok) into
// single-beat AXI reads, keeping up to MAX_OUTSTANDING reads in flight and
// silently dropping responses to fetches that a pipeline flush has cancelled.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   inst_sram_req_i/addr_i      fetch request and physical address
//   inst_sram_addr_ok_o         request accepted this cycle (combinational)
//   inst_sram_data_ok_o/rdata_o registered one-cycle data return
//   cancel_i                    flush: discard every outstanding fetch
//   ar*_o / arready_i           AXI read address channel (single beat, INCR, 4 bytes)
//   r*_i / rready_o             AXI read data channel (rid/rresp unused)

module inst_sram_axi_rd #(
   parameter logic [3:0]  AXI_ID          = 4'd0,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_req_i,
   input  logic [31:0] inst_sram_addr_i,
   output logic        inst_sram_addr_ok_o,
   output logic        inst_sram_data_ok_o,
   output logic [31:0] inst_sram_rdata_o,
   input  logic        cancel_i,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [7:0]  arlen_o,
   output logic [2:0]  arsize_o,
   output logic [1:0]  arburst_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [3:0]  rid_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   typedef enum logic {
      AR_IDLE,
      AR_BUSY
   } ar_state_e;

   ar_state_e   state_q, state_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  disc_cnt_q, disc_cnt_d;
   logic [31:0] araddr_q, araddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        data_ok_q, data_ok_d;
   logic        addr_hs;
   logic        r_hs;

   // Response ID and status carry no information for in-order single-beat fetches.
   logic unused_r_fields;
   assign unused_r_fields = ^{rid_i, rresp_i};

   assign inst_sram_addr_ok_o = inst_sram_req_i && (state_q == AR_IDLE) &&
                                (out_cnt_q < MAX_CNT) && !cancel_i;
   assign addr_hs   = inst_sram_addr_ok_o;
   assign rready_o  = (out_cnt_q != 2'd0);
   assign r_hs      = rvalid_i && rready_o && rlast_i;

   assign arid_o    = AXI_ID;
   assign arlen_o   = 8'd0;
   assign arsize_o  = 3'd2;
   assign arburst_o = 2'b01;
   assign arvalid_o = (state_q == AR_BUSY);
   assign araddr_o  = araddr_q;

   assign inst_sram_data_ok_o = data_ok_q;
   assign inst_sram_rdata_o   = rdata_q;

   // AR channel: one address in flight; cancel does not retract an issued arvalid.
   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      case (state_q)
         AR_IDLE: begin
            if (addr_hs) begin
               state_d  = AR_BUSY;
               araddr_d = inst_sram_addr_i;
            end
         end
         AR_BUSY: begin
            if (arready_i) begin
               state_d = AR_IDLE;
            end
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // Outstanding / discard bookkeeping and registered response path.
   always_comb begin
      out_cnt_d  = out_cnt_q;
      disc_cnt_d = disc_cnt_q;
      data_ok_d  = 1'b0;
      rdata_d    = rdata_q;

      if (addr_hs && !r_hs) begin
         out_cnt_d = out_cnt_q + 2'd1;
      end else if (!addr_hs && r_hs) begin
         out_cnt_d = out_cnt_q - 2'd1;
      end

      if (cancel_i) begin
         // Everything still owed gets dropped; a beat consumed this very cycle
         // is already gone, so it is not counted again.
         disc_cnt_d = r_hs ? (out_cnt_q - 2'd1) : out_cnt_q;
      end else if (r_hs) begin
         if (disc_cnt_q != 2'd0) begin
            disc_cnt_d = disc_cnt_q - 2'd1;
         end else begin
            data_ok_d = 1'b1;
            rdata_d   = rdata_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= AR_IDLE;
         out_cnt_q  <= 2'd0;
         disc_cnt_q <= 2'd0;
         araddr_q   <= 32'd0;
         rdata_q    <= 32'd0;
         data_ok_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_cnt_q  <= out_cnt_d;
         disc_cnt_q <= disc_cnt_d;
         araddr_q   <= araddr_d;
         rdata_q    <= rdata_d;
         data_ok_q  <= data_ok_d;
      end
   end

endmodule

// File: tb/tb_inst_sram_axi_rd.sv
// tb/tb_inst_sram_axi_rd.sv - self-checking bench for inst_sram_axi_rd

module tb_inst_sram_axi_rd;

   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_sram_req_i;
   logic [31:0] inst_sram_addr_i;
   logic        inst_sram_addr_ok_o;
   logic        inst_sram_data_ok_o;
   logic [31:0] inst_sram_rdata_o;
   logic        cancel_i;
   logic [3:0]  arid_o;
   logic [31:0] araddr_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic [1:0]  arburst_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [3:0]  rid_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rlast_i;
   logic        rvalid_i;
   logic        rready_o;

   inst_sram_axi_rd dut (
      .clk                 (clk),
      .rst                 (rst),
      .inst_sram_req_i     (inst_sram_req_i),
      .inst_sram_addr_i    (inst_sram_addr_i),
      .inst_sram_addr_ok_o (inst_sram_addr_ok_o),
      .inst_sram_data_ok_o (inst_sram_data_ok_o),
      .inst_sram_rdata_o   (inst_sram_rdata_o),
      .cancel_i            (cancel_i),
      .arid_o              (arid_o),
      .araddr_o            (araddr_o),
      .arlen_o             (arlen_o),
      .arsize_o            (arsize_o),
      .arburst_o           (arburst_o),
      .arvalid_o           (arvalid_o),
      .arready_i           (arready_i),
      .rid_i               (rid_i),
      .rdata_i             (rdata_i),
      .rresp_i             (rresp_i),
      .rlast_i             (rlast_i),
      .rvalid_i            (rvalid_i),
      .rready_o            (rready_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory contents seen by the bench slave.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1c000000) return 32'h02800c0c;
      return {a[15:0], ~a[15:0]};
   endfunction

   // ---------------- AXI slave + reference model ----------------
   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } sl_t;
   typedef struct {
      logic [31:0] addr;
      bit          live;
   } pe_t;

   sl_t         sq[$];
   pe_t         pq[$];
   int          cyc = 0;
   int          slv_delay = 1;
   int          ar_cnt = 0;
   logic        nxt_rv = 1'b0;
   logic [31:0] nxt_rd = 32'd0;

   bit          m_ar_pend;
   logic [31:0] m_ar_addr;
   bit          m_dok;
   logic [31:0] m_rdata;
   bit          e_aok, e_rready, m_rhs;
   pe_t         m_e;

   always @(posedge clk) begin
      #1;
      rvalid_i = nxt_rv;
      rdata_i  = nxt_rd;
   end

   always @(negedge clk) begin
      if (rst) begin
         chkb("rst_arvalid", arvalid_o, 1'b0);
         chkb("rst_rready", rready_o, 1'b0);
         chkb("rst_data_ok", inst_sram_data_ok_o, 1'b0);
         chk("rst_rdata", inst_sram_rdata_o, 32'd0);
         chk("rst_araddr", araddr_o, 32'd0);
         pq.delete();
         sq.delete();
         m_ar_pend = 1'b0;
         m_ar_addr = 32'd0;
         m_dok     = 1'b0;
         m_rdata   = 32'd0;
         nxt_rv    = 1'b0;
      end else begin
         // Outputs this cycle from the model state.
         e_rready = (pq.size() != 0);
         e_aok    = inst_sram_req_i && !m_ar_pend && (pq.size() < MAX) && !cancel_i;
         chkb("addr_ok", inst_sram_addr_ok_o, e_aok);
         chkb("arvalid", arvalid_o, m_ar_pend);
         if (m_ar_pend) chk("araddr", araddr_o, m_ar_addr);
         chkb("rready", rready_o, e_rready);
         chkb("data_ok", inst_sram_data_ok_o, m_dok);
         if (m_dok) chk("rdata", inst_sram_rdata_o, m_rdata);
         chk("ar_const", {arid_o, arlen_o, arsize_o, arburst_o, 15'd0},
             {4'd0, 8'd0, 3'd2, 2'b01, 15'd0});

         // Advance the model: fetches leave in order; a flush kills all owed ones.
         m_rhs = rvalid_i && e_rready;
         m_dok = 1'b0;
         if (m_rhs) begin
            m_e = pq.pop_front();
            if (m_e.live && !cancel_i) begin
               m_dok   = 1'b1;
               m_rdata = mem_word(m_e.addr);
            end
         end
         if (cancel_i) foreach (pq[i]) pq[i].live = 1'b0;
         if (m_ar_pend && arready_i) m_ar_pend = 1'b0;
         if (e_aok) begin
            pq.push_back('{inst_sram_addr_i, 1'b1});
            m_ar_pend = 1'b1;
            m_ar_addr = inst_sram_addr_i;
         end

         // Slave: serve reads slv_delay cycles after the AR handshake.
         if (rvalid_i && rready_o && sq.size() != 0) void'(sq.pop_front());
         if (arvalid_o && arready_i) begin
            sq.push_back('{araddr_o, cyc + slv_delay});
            ar_cnt++;
         end
         if (sq.size() != 0 && sq[0].rdy <= cyc + 1) begin
            nxt_rv = 1'b1;
            nxt_rd = mem_word(sq[0].addr);
         end else begin
            nxt_rv = 1'b0;
         end
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input bit r, input logic [31:0] a, input bit c, input bit ar);
      @(posedge clk);
      #1;
      inst_sram_req_i  = r;
      inst_sram_addr_i = a;
      cancel_i         = c;
      arready_i        = ar;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   int acc[3];
   int idx, n, ar0;
   bit got;

   initial begin
      rst = 1'b1;
      inst_sram_req_i = 1'b0;
      inst_sram_addr_i = 32'd0;
      cancel_i = 1'b0;
      arready_i = 1'b1;
      rid_i = 4'd0;
      rresp_i = 2'd0;
      rlast_i = 1'b1;
      rvalid_i = 1'b0;
      rdata_i = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chkb("reset_data_ok", inst_sram_data_ok_o, 1'b0);
      chkb("reset_arvalid", arvalid_o, 1'b0);

      // Single fetch, best-case latency.
      slv_delay = 1;
      drive(1'b1, 32'h1c000000, 1'b0, 1'b1);
      @(negedge clk) chkb("t1_addr_ok_T", inst_sram_addr_ok_o, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      chkb("t1_arvalid_T1", arvalid_o, 1'b1);
      chk("t1_araddr_T1", araddr_o, 32'h1c000000);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk) chkb("t1_data_ok_T2", inst_sram_data_ok_o, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      chkb("t1_data_ok_T3", inst_sram_data_ok_o, 1'b1);
      chk("t1_rdata_T3", inst_sram_rdata_o, 32'h02800c0c);
      idle(4);

      // Outstanding limit with slow responses.
      slv_delay = 10;
      idx = 0;
      acc = '{-1, -1, -1};
      for (int k = 0; k < 16; k++) begin
         drive(idx < 3, 32'(idx * 4), 1'b0, 1'b1);
         @(negedge clk);
         if (inst_sram_addr_ok_o && idx < 3) begin
            acc[idx] = k;
            idx++;
         end
      end
      chk("t2_acc_0x0", acc[0], 32'd0);
      chk("t2_acc_0x4", acc[1], 32'd2);
      chk("t2_acc_0x8", acc[2], 32'd12);
      idle(30);

      // AR backpressure.
      slv_delay = 1;
      drive(1'b1, 32'h40, 1'b0, 1'b0);
      @(negedge clk) chkb("t3_accept", inst_sram_addr_ok_o, 1'b1);
      ar0 = ar_cnt;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'h44, 1'b0, 1'b0);
         @(negedge clk);
         chkb("t3_hold_arvalid", arvalid_o, 1'b1);
         chk("t3_hold_araddr", araddr_o, 32'h40);
         chkb("t3_hold_addr_ok", inst_sram_addr_ok_o, 1'b0);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      idle(6);
      chk("t3_single_ar", 32'(ar_cnt - ar0), 32'd1);

      // Two outstanding, double cancel pulse, then a new fetch.
      slv_delay = 4;
      n = 0;
      drive(1'b1, 32'h10, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b1, 32'h14, 1'b0, 1'b1);
      @(negedge clk) chkb("t4_second_accept", inst_sram_addr_ok_o, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b1, 32'h100, 1'b1, 1'b1);
      @(negedge clk) chkb("t4_cancel_blocks", inst_sram_addr_ok_o, 1'b0);
      drive(1'b1, 32'h100, 1'b1, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         drive(!got, 32'h100, 1'b0, 1'b1);
         @(negedge clk);
         if (inst_sram_addr_ok_o) got = 1'b1;
         if (inst_sram_data_ok_o) begin
            n++;
            chk("t4_rdata", inst_sram_rdata_o, 32'h0100feff);
         end
      end
      chk("t4_data_ok_count", n, 32'd1);
      idle(5);

      // Cancel in the same cycle as an R handshake, out_cnt == 2.
      slv_delay = 3;
      n = 0;
      drive(1'b1, 32'h20, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b1, 32'h24, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk) chkb("t5_rready_at_cancel", rready_o, 1'b1);
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 32'd0, 1'b0, 1'b1);
         @(negedge clk);
         if (inst_sram_data_ok_o) n++;
      end
      chk("t5_no_data_ok", n, 32'd0);
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive(!got, 32'h30, 1'b0, 1'b1);
         @(negedge clk);
         if (inst_sram_addr_ok_o) got = 1'b1;
         if (inst_sram_data_ok_o) begin
            n++;
            chk("t5_new_rdata", inst_sram_rdata_o, 32'h0030ffcf);
         end
      end
      chk("t5_new_data_ok_count", n, 32'd1);
      idle(4);

      // Asynchronous reset with arvalid and data_ok both high.
      slv_delay = 1;
      drive(1'b1, 32'h60, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b1, 32'h64, 1'b0, 1'b1);
      @(negedge clk) chkb("t6_accept_0x64", inst_sram_addr_ok_o, 1'b1);
      @(posedge clk);
      #1;
      inst_sram_req_i = 1'b0;
      arready_i = 1'b0;
      #1;
      chkb("t6_pre_arvalid", arvalid_o, 1'b1);
      chkb("t6_pre_data_ok", inst_sram_data_ok_o, 1'b1);
      chkb("t6_pre_rready", rready_o, 1'b1);
      #1 rst = 1'b1;
      #1;
      chkb("t6_async_arvalid", arvalid_o, 1'b0);
      chkb("t6_async_data_ok", inst_sram_data_ok_o, 1'b0);
      chkb("t6_async_rready", rready_o, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      arready_i = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 32'd0, 1'b0, 1'b1);
         @(negedge clk);
         if (inst_sram_data_ok_o) n++;
      end
      chk("t6_no_data_ok_after_reset", n, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
